// File: rtl/riscvsc_mmio_pkg.sv
// Shared decode constants for the data-side bus: MMIO register offsets, CTRL bit positions
// and the access target select.
package riscvsc_mmio_pkg;

    localparam logic [7:0] OFS_GPIO_OUT    = 8'h00;
    localparam logic [7:0] OFS_GPIO_IN     = 8'h04;
    localparam logic [7:0] OFS_MTIME_LO    = 8'h08;
    localparam logic [7:0] OFS_MTIME_HI    = 8'h0C;
    localparam logic [7:0] OFS_MTIMECMP_LO = 8'h10;
    localparam logic [7:0] OFS_MTIMECMP_HI = 8'h14;
    localparam logic [7:0] OFS_CTRL        = 8'h18;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_IE   = 1;
    localparam int unsigned CTRL_PEND = 2;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_MMIO,
        SEL_NONE
    } dbus_sel_t;

endpackage

// File: rtl/riscvsc_dmem.sv
// Word RAM with asynchronous read and synchronous write; contents are never reset.
module riscvsc_dmem #(
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wd,
    output logic [31:0]   rd
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wd;
        end
    end

    // Read sees the pre-edge contents, so a same-cycle write returns old data.
    assign rd = mem_q[addr];

endmodule

// File: rtl/riscvsc.sv
// Data-side bus unit: decodes core data accesses to the word RAM or the MMIO block
// (GPIO, 64-bit machine timer with compare, timer interrupt state).
module riscvsc_dbus
    import riscvsc_mmio_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
    parameter int unsigned GPIO_W    = 8,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [31:0]       ALUResult,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH) * 33'd4;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    dbus_sel_t   sel;
    logic [7:0]  ofs;
    logic        mmio_we;
    logic [31:0] ram_rd;

    logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
    logic [GPIO_W-1:0] sync1_q, sync2_q;
    logic [63:0]       mtime_q, mtime_d;
    logic [63:0]       mtimecmp_q, mtimecmp_d;
    logic              en_q, en_d, ie_q, ie_d, pend_q, pend_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic              tick;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^ALUResult[1:0];

    always_comb begin
        if ({1'b0, ALUResult} < RAM_BYTES) begin
            sel = SEL_RAM;
        end else if (ALUResult[31:8] == MMIO_BASE[31:8]) begin
            sel = SEL_MMIO;
        end else begin
            sel = SEL_NONE;
        end
    end

    assign ofs     = {ALUResult[7:2], 2'b00};
    assign mmio_we = MemWrite && (sel == SEL_MMIO);

    riscvsc_dmem #(
        .DEPTH (DEPTH)
    ) u_dmem (
        .clk  (clk),
        .we   (MemWrite && (sel == SEL_RAM)),
        .addr (ALUResult[AW+1:2]),
        .wd   (WriteData),
        .rd   (ram_rd)
    );

    assign tick = en_q && (pre_q == PRE_MAX);

    always_comb begin
        gpio_out_d = gpio_out_q;
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
        ie_d       = ie_q;
        pre_d      = pre_q;

        if (en_q) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end

        // A software write to either mtime half swallows this cycle's tick.
        if (mmio_we && ofs == OFS_MTIME_LO) begin
            mtime_d[31:0] = WriteData;
        end else if (mmio_we && ofs == OFS_MTIME_HI) begin
            mtime_d[63:32] = WriteData;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        if (mmio_we) begin
            unique case (ofs)
                OFS_GPIO_OUT:    gpio_out_d = WriteData[GPIO_W-1:0];
                OFS_MTIMECMP_LO: mtimecmp_d[31:0] = WriteData;
                OFS_MTIMECMP_HI: mtimecmp_d[63:32] = WriteData;
                OFS_CTRL: begin
                    en_d = WriteData[CTRL_EN];
                    ie_d = WriteData[CTRL_IE];
                end
                default: ;
            endcase
        end

        // Set beats the W1C clear when both land on the same edge.
        pend_d = (en_q && (mtime_q >= mtimecmp_q)) ||
                 (pend_q && !(mmio_we && ofs == OFS_CTRL && WriteData[CTRL_PEND]));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            en_q       <= 1'b0;
            ie_q       <= 1'b0;
            pend_q     <= 1'b0;
            pre_q      <= '0;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            ie_q       <= ie_d;
            pend_q     <= pend_d;
            pre_q      <= pre_d;
        end
    end

    always_comb begin
        ReadData = '0;
        unique case (sel)
            SEL_RAM: ReadData = ram_rd;
            SEL_MMIO: begin
                unique case (ofs)
                    OFS_GPIO_OUT:    ReadData = 32'(gpio_out_q);
                    OFS_GPIO_IN:     ReadData = 32'(sync2_q);
                    OFS_MTIME_LO:    ReadData = mtime_q[31:0];
                    OFS_MTIME_HI:    ReadData = mtime_q[63:32];
                    OFS_MTIMECMP_LO: ReadData = mtimecmp_q[31:0];
                    OFS_MTIMECMP_HI: ReadData = mtimecmp_q[63:32];
                    OFS_CTRL:        ReadData = {29'd0, pend_q, ie_q, en_q};
                    default:         ReadData = '0;
                endcase
            end
            default: ReadData = '0;
        endcase
    end

    assign gpio_out  = gpio_out_q;
    assign timer_irq = pend_q & ie_q;

endmodule

// File: tb/tb_riscvsc_dbus.sv
// Directed bench for riscvsc_dbus: vector table for decode/RAM/GPIO, hand sequences for timer,
// interrupt, write priority and asynchronous reset.
module tb_riscvsc_dbus;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] rd, rd4;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio, gpio4;
    logic        irq, irq4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscvsc_dbus dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (rd),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio),
        .timer_irq (irq)
    );

    riscvsc_dbus #(
        .PRESCALE (4)
    ) dut4 (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (rd4),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio4),
        .timer_irq (irq4)
    );

    localparam logic [31:0] GOUT  = 32'h8000_0000;
    localparam logic [31:0] GIN   = 32'h8000_0004;
    localparam logic [31:0] MTLO  = 32'h8000_0008;
    localparam logic [31:0] MTHI  = 32'h8000_000C;
    localparam logic [31:0] CMPLO = 32'h8000_0010;
    localparam logic [31:0] CMPHI = 32'h8000_0014;
    localparam logic [31:0] CTRL  = 32'h8000_0018;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic [7:0]  exp_gpio;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        ALUResult = a;
        WriteData = d;
        step();
        MemWrite  = 1'b0;
    endtask

    task automatic rchk(input string name, input logic [31:0] a, input logic [31:0] exp);
        MemWrite  = 1'b0;
        ALUResult = a;
        #1;
        check(name, rd, exp);
    endtask

    task automatic rchk4(input string name, input logic [31:0] a, input logic [31:0] exp);
        MemWrite  = 1'b0;
        ALUResult = a;
        #1;
        check(name, rd4, exp);
    endtask

    initial begin
        vecs[0]  = '{1'b0, CTRL,          32'h0,        32'h0,        8'h00};
        vecs[1]  = '{1'b0, CMPLO,         32'h0,        32'hFFFF_FFFF, 8'h00};
        vecs[2]  = '{1'b0, CMPHI,         32'h0,        32'hFFFF_FFFF, 8'h00};
        vecs[3]  = '{1'b0, MTLO,          32'h0,        32'h0,        8'h00};
        vecs[4]  = '{1'b0, MTHI,          32'h0,        32'h0,        8'h00};
        vecs[5]  = '{1'b1, 32'h10,        32'hDEAD_BEEF, 32'h0,       8'h00};
        vecs[6]  = '{1'b0, 32'h10,        32'h0,        32'hDEAD_BEEF, 8'h00};
        vecs[7]  = '{1'b0, 32'h13,        32'h0,        32'hDEAD_BEEF, 8'h00};
        vecs[8]  = '{1'b1, 32'h0,         32'h1111_1111, 32'h0,       8'h00};
        vecs[9]  = '{1'b1, 32'h3FC,       32'hCAFE_F00D, 32'h0,       8'h00};
        vecs[10] = '{1'b1, 32'h400,       32'h2222_2222, 32'h0,       8'h00};
        vecs[11] = '{1'b0, 32'h0,         32'h0,        32'h1111_1111, 8'h00};
        vecs[12] = '{1'b0, 32'h3FC,       32'h0,        32'hCAFE_F00D, 8'h00};
        vecs[13] = '{1'b0, 32'h400,       32'h0,        32'h0,        8'h00};
        vecs[14] = '{1'b1, 32'h4000_0000, 32'h1234_5678, 32'h0,       8'h00};
        vecs[15] = '{1'b0, 32'h4000_0000, 32'h0,        32'h0,        8'h00};
        vecs[16] = '{1'b1, GOUT,          32'h1A5,      32'h0,        8'hA5};
        vecs[17] = '{1'b0, GOUT,          32'h0,        32'hA5,       8'hA5};
        vecs[18] = '{1'b1, GIN,           32'hFF,       32'h0,        8'hA5};
        vecs[19] = '{1'b0, GIN,           32'h0,        32'h0,        8'hA5};
        vecs[20] = '{1'b1, CMPLO,         32'h55,       32'h0,        8'hA5};
        vecs[21] = '{1'b0, CMPLO,         32'h0,        32'h55,       8'hA5};
        vecs[22] = '{1'b1, CMPLO,         32'hFFFF_FFFF, 32'h0,       8'hA5};
        vecs[23] = '{1'b0, 32'h8000_001C, 32'h0,        32'h0,        8'hA5};
        vecs[24] = '{1'b1, 32'h8000_0020, 32'h1,        32'h0,        8'hA5};
        vecs[25] = '{1'b0, CTRL,          32'h0,        32'h0,        8'hA5};
        vecs[26] = '{1'b1, 32'h8000_0100, 32'h5A,       32'h0,        8'hA5};
        vecs[27] = '{1'b0, GOUT,          32'h0,        32'hA5,       8'hA5};

        reset     = 1'b1;
        MemWrite  = 1'b0;
        ALUResult = '0;
        WriteData = '0;
        gpio_in   = 8'h00;
        step();
        step();
        reset = 1'b0;
        check("reset_irq", 32'(irq), 32'h0);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].we) begin
                wr(vecs[i].addr, vecs[i].data);
            end else begin
                rchk($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp_rd);
            end
            check($sformatf("vec%0d_gpio", i), 32'(gpio), 32'(vecs[i].exp_gpio));
        end

        // Two-flop synchronizer latency.
        gpio_in = 8'h3C;
        step();
        rchk("gpio_in_edge1", GIN, 32'h0);
        step();
        rchk("gpio_in_edge2", GIN, 32'h3C);

        // Carry from lo into hi; the PRESCALE=4 copy sees the same writes.
        wr(MTLO, 32'hFFFF_FFFE);
        wr(MTHI, 32'h0);
        wr(CTRL, 32'h1);
        step();
        rchk("carry_lo_t1", MTLO, 32'hFFFF_FFFF);
        rchk("carry_hi_t1", MTHI, 32'h0);
        step();
        rchk("carry_lo_t2", MTLO, 32'h0);
        rchk("carry_hi_t2", MTHI, 32'h1);
        step();
        rchk4("pre4_lo_c3", MTLO, 32'hFFFF_FFFE);
        step();
        rchk4("pre4_lo_c4", MTLO, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) step();
        rchk4("pre4_lo_c8", MTLO, 32'h0);
        rchk4("pre4_hi_c8", MTHI, 32'h1);
        wr(CTRL, 32'h0);

        // Interrupt: compare uses registered mtime, so PEND lands one edge after mtime==cmp.
        wr(MTLO, 32'h0);
        wr(MTHI, 32'h0);
        wr(CMPLO, 32'd10);
        wr(CMPHI, 32'h0);
        wr(CTRL, 32'h3);
        for (int i = 0; i < 10; i++) step();
        rchk("irq_mtime10", MTLO, 32'd10);
        check("irq_before", 32'(irq), 32'h0);
        step();
        check("irq_set", 32'(irq), 32'h1);
        rchk("irq_ctrl", CTRL, 32'h7);
        wr(CTRL, 32'h7);
        rchk("set_wins_ctrl", CTRL, 32'h7);
        check("set_wins_irq", 32'(irq), 32'h1);
        wr(CMPHI, 32'hFFFF_FFFF);
        wr(CMPLO, 32'hFFFF_FFFF);
        wr(CTRL, 32'h7);
        rchk("w1c_ctrl", CTRL, 32'h3);
        check("w1c_irq", 32'(irq), 32'h0);
        wr(CMPHI, 32'h0);
        wr(CMPLO, 32'h0);
        wr(CTRL, 32'h1);
        rchk("ie0_ctrl", CTRL, 32'h5);
        check("ie0_irq", 32'(irq), 32'h0);
        step();
        check("ie0_irq_later", 32'(irq), 32'h0);

        // Software write to mtime beats the tick and the other half holds.
        wr(MTLO, 32'hFFFF_FFFF);
        wr(MTHI, 32'h7);
        rchk("prio_hi_lo", MTLO, 32'hFFFF_FFFF);
        rchk("prio_hi_hi", MTHI, 32'h7);
        wr(MTLO, 32'h5);
        rchk("prio_lo_lo", MTLO, 32'h5);
        rchk("prio_lo_hi", MTHI, 32'h7);

        // Asynchronous reset between edges.
        wr(CTRL, 32'h3);
        check("pre_rst_irq", 32'(irq), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_irq4", 32'(irq4), 32'h0);
        check("rst_gpio", 32'(gpio), 32'h0);
        rchk("rst_ctrl", CTRL, 32'h0);
        rchk("rst_mtlo", MTLO, 32'h0);
        rchk("rst_mthi", MTHI, 32'h0);
        rchk("rst_cmplo", CMPLO, 32'hFFFF_FFFF);
        rchk("rst_cmphi", CMPHI, 32'hFFFF_FFFF);
        @(negedge clk);
        reset = 1'b0;
        step();
        rchk("rst_ram", 32'h10, 32'hDEAD_BEEF);
        rchk("rst_mtlo_idle", MTLO, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
